frame_seq_ctrl: RTL and testbench

Sequencer for the 4x4 × 32-bit register frame. It accepts a 16-word frame over a valid/ready stream in column-major order and stages it. It drives the frame's `write`/`Small_or_Big` controls to load column 0, then columns 1–3. It then issues a fixed number of round-enable pulses to the downstream round datapath and holds a `done` flag until acknowledged.

---
 rtl/frame_seq_pkg.sv | 23 ++
 rtl/frame_stage.sv | 25 ++
 rtl/frame_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_frame_seq_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_seq_pkg.sv
// Shared state encoding, frame geometry and the column 1-3 load order.
package frame_seq_pkg;

  localparam int FRAME_WORDS = 16;
  localparam int WORD_W      = 32;
  localparam int COLS        = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_SMALL,
    WR_SMALL,
    LOAD_BIG,
    WR_BIG,
    ROUND,
    DONE
  } state_t;

  // Handshake k of the big load lands at 4*(k mod 4) + 1 + k/4.
  function automatic logic [3:0] big_index(input logic [3:0] k);
    return {k[1:0], 2'b00} + 4'd1 + {2'b00, k[3:2]};
  endfunction

endpackage

// File: rtl/frame_stage.sv
// 16x32 staging buffer, one word written per enabled cycle, cleared by reset.
module frame_stage
  import frame_seq_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          we,
  input  logic [3:0]                    idx,
  input  logic [WORD_W-1:0]             wdat,
  output logic [FRAME_WORDS*WORD_W-1:0] frame_flat
);

  logic [FRAME_WORDS-1:0][WORD_W-1:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (we) begin
      mem[idx] <= wdat;
    end
  end

  assign frame_flat = mem;

endmodule

// File: rtl/frame_seq_ctrl.sv
// Frame sequencer: stages 16 words, strobes column-0 then columns 1-3 writes, runs ROUNDS round
// pulses, holds done until ack. Optional FRAME_SEQ_ABORT_EN adds an abort input.
module frame_seq_ctrl
  import frame_seq_pkg::*;
#(
  parameter  int ROUNDS  = 10,
  localparam int ROUND_W = $clog2(ROUNDS + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WORD_W-1:0]             in_word,
  output logic [FRAME_WORDS*WORD_W-1:0] frame_flat,
  output logic                          rf_write,
  output logic                          rf_small_or_big,
  output logic                          round_en,
  output logic [ROUND_W-1:0]            round_idx,
  output logic                          busy,
  output logic                          done,
  input  logic                          done_ack
`ifdef FRAME_SEQ_ABORT_EN
  ,
  input  logic                          abort
`endif
);

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS - 1);

  state_t     state;
  logic [3:0] wcnt;
  logic       abort_hit;
  logic       stage_we;
  logic [3:0] stage_idx;

`ifdef FRAME_SEQ_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign in_ready  = (state == LOAD_SMALL) || (state == LOAD_BIG);
  assign busy      = (state != IDLE);
  assign stage_we  = in_ready && in_valid && !abort_hit;
  assign stage_idx = (state == LOAD_SMALL) ? {wcnt[1:0], 2'b00} : big_index(wcnt);

  frame_stage u_stage (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (stage_we),
    .idx        (stage_idx),
    .wdat       (in_word),
    .frame_flat (frame_flat)
  );

  // Strobes are set on the edge entering their state so they are registered for that whole cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      wcnt            <= '0;
      round_idx       <= '0;
      rf_write        <= 1'b0;
      rf_small_or_big <= 1'b0;
      round_en        <= 1'b0;
      done            <= 1'b0;
    end else begin
      rf_write        <= 1'b0;
      rf_small_or_big <= 1'b0;
      round_en        <= 1'b0;
      case (state)
        IDLE: begin
          wcnt <= '0;
          if (start) state <= LOAD_SMALL;
        end
        LOAD_SMALL: if (in_valid) begin
          if (wcnt == 4'd3) begin
            wcnt     <= '0;
            state    <= WR_SMALL;
            rf_write <= 1'b1;
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        WR_SMALL: state <= LOAD_BIG;
        LOAD_BIG: if (in_valid) begin
          if (wcnt == 4'd11) begin
            wcnt            <= '0;
            state           <= WR_BIG;
            rf_write        <= 1'b1;
            rf_small_or_big <= 1'b1;
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        WR_BIG: begin
          state     <= ROUND;
          round_idx <= '0;
          round_en  <= 1'b1;
        end
        ROUND: begin
          if (round_idx == LAST_ROUND) begin
            state     <= DONE;
            round_idx <= '0;
            done      <= 1'b1;
          end else begin
            round_idx <= round_idx + ROUND_W'(1);
            round_en  <= 1'b1;
          end
        end
        DONE: if (done_ack) begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      // Abort outranks everything above; staged words are kept.
      if (abort_hit) begin
        state           <= IDLE;
        wcnt            <= '0;
        round_idx       <= '0;
        rf_write        <= 1'b0;
        rf_small_or_big <= 1'b0;
        round_en        <= 1'b0;
        done            <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Randomised bench for frame_seq_ctrl against a cycle-count and placement model of the sequencer.
module tb_frame_seq_ctrl;

  localparam int RND  = 10;
  localparam int MAXC = 400;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         in_valid = 1'b0;
  logic         done_ack = 1'b0;
  logic [31:0]  in_word = '0;
  logic         in_ready, rf_write, rf_small_or_big, round_en, busy, done;
  logic [511:0] frame_flat;
  logic [3:0]   round_idx;
`ifdef FRAME_SEQ_ABORT_EN
  logic         abort = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  frame_seq_ctrl #(.ROUNDS(RND)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_word         (in_word),
    .frame_flat      (frame_flat),
    .rf_write        (rf_write),
    .rf_small_or_big (rf_small_or_big),
    .round_en        (round_en),
    .round_idx       (round_idx),
    .busy            (busy),
    .done            (done),
    .done_ack        (done_ack)
`ifdef FRAME_SEQ_ABORT_EN
    ,
    .abort           (abort)
`endif
  );

  logic [31:0] words[16];
  bit          vpat[MAXC];
  bit          spurious;
  int          hs, done_cyc, sob_stray;
  int          hs_cyc[$], rf_cyc[$], ren_cyc[$], ren_idx[$];
  bit          rf_sobv[$];
  int          e_hs[$];
  int          e_ws, e_wb, e_done;

  // Word j of the stream goes to row j%4, column j/4 of a column-major 4x4 frame.
  function automatic logic [511:0] model_frame();
    logic [511:0] f = '0;
    for (int j = 0; j < 16; j++) f[32*(4*(j%4) + j/4) +: 32] = words[j];
    return f;
  endfunction

  // Handshake and phase cycles from the valid pattern, with start taken in cycle 0.
  task automatic model_timing();
    int c = 1;
    int cnt = 0;
    e_hs.delete();
    while (cnt < 4 && c < MAXC - 1) begin
      if (vpat[c]) begin e_hs.push_back(c); cnt++; end
      c++;
    end
    e_ws = c;
    c = e_ws + 1;
    cnt = 0;
    while (cnt < 12 && c < MAXC - 1) begin
      if (vpat[c]) begin e_hs.push_back(c); cnt++; end
      c++;
    end
    e_wb = c;
    e_done = e_wb + RND + 1;
  endtask

  task automatic set_pattern(input int mode);
    for (int c = 0; c < MAXC; c++) begin
      case (mode)
        0:       vpat[c] = 1'b1;
        1:       vpat[c] = (c % 2) == 1;
        default: vpat[c] = ($urandom_range(0, 3) != 0);
      endcase
    end
  endtask

  task automatic run_frame(input int stop_hs);
    hs = 0; done_cyc = -1; sob_stray = 0;
    hs_cyc.delete(); rf_cyc.delete(); rf_sobv.delete(); ren_cyc.delete(); ren_idx.delete();
    for (int c = 0; c < MAXC; c++) begin
      @(posedge clk); #1;
      start    = (c == 0) ? 1'b1 : (spurious ? ($urandom_range(0, 2) == 0) : 1'b0);
      in_valid = (c == 0) ? 1'b0 : vpat[c];
      in_word  = (hs < 16) ? words[hs] : $urandom;
      @(negedge clk);
      if (in_valid && in_ready) begin hs_cyc.push_back(c); hs++; end
      if (rf_write) begin rf_cyc.push_back(c); rf_sobv.push_back(rf_small_or_big); end
      else if (rf_small_or_big) sob_stray++;
      if (round_en) begin ren_cyc.push_back(c); ren_idx.push_back(int'(round_idx)); end
      if (done) begin done_cyc = c; break; end
      if (hs >= stop_hs) break;
    end
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if ({in_ready, rf_write, rf_small_or_big, round_en, busy, done} !== 6'b0 || round_idx !== 4'd0)
      begin bad++; $display("FAIL reset_ctrl: got %b idx %0d want 0", {in_ready, rf_write, rf_small_or_big, round_en, busy, done}, round_idx); end
    total++;
    if (frame_flat !== '0) begin bad++; $display("FAIL reset_frame: got %h want 0", frame_flat); end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || rf_write !== 1'b0) begin bad++; $display("FAIL reset_idle: busy %b rf_write %b want 0 0", busy, rf_write); end
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 16; j++) words[j] = 32'(j);
    set_pattern(0);
    spurious = 1'b1;
    run_frame(99);
    spurious = 1'b0;
    total++;
    if (rf_cyc.size() != 2) begin bad++; $display("FAIL b2b_rf_count: got %0d want 2", rf_cyc.size()); end
    else begin
      total++;
      if (rf_cyc[0] != 5 || rf_sobv[0] !== 1'b0) begin bad++; $display("FAIL b2b_wr_small: cycle %0d sob %b want 5 0", rf_cyc[0], rf_sobv[0]); end
      total++;
      if (rf_cyc[1] != 18 || rf_sobv[1] !== 1'b1) begin bad++; $display("FAIL b2b_wr_big: cycle %0d sob %b want 18 1", rf_cyc[1], rf_sobv[1]); end
    end
    total++;
    if (sob_stray != 0) begin bad++; $display("FAIL b2b_sob_stray: got %0d want 0", sob_stray); end
    total++;
    if (frame_flat[4*32 +: 32] !== 32'h1 || frame_flat[1*32 +: 32] !== 32'h4 || frame_flat[15*32 +: 32] !== 32'hF)
      begin bad++; $display("FAIL b2b_words: w4 %h w1 %h w15 %h want 1 4 f", frame_flat[4*32 +: 32], frame_flat[1*32 +: 32], frame_flat[15*32 +: 32]); end
    total++;
    if (frame_flat !== model_frame()) begin bad++; $display("FAIL b2b_frame: got %h want %h", frame_flat, model_frame()); end
    total++;
    if (done_cyc != 19 + RND) begin bad++; $display("FAIL b2b_done_cycle: got %0d want %0d", done_cyc, 19 + RND); end
    total++;
    if (ren_cyc.size() != RND) begin bad++; $display("FAIL b2b_round_count: got %0d want %0d", ren_cyc.size(), RND); end
    else for (int i = 0; i < RND; i++) begin
      total++;
      if (ren_cyc[i] != 19 + i || ren_idx[i] != i)
        begin bad++; $display("FAIL b2b_round_%0d: cycle %0d idx %0d want %0d %0d", i, ren_cyc[i], ren_idx[i], 19 + i, i); end
    end
    // done held 7 cycles in total with start pulses ignored, then ack together with start.
    for (int h = 0; h < 6; h++) begin
      @(posedge clk); #1; start = (h % 2 == 0);
      @(negedge clk);
      total++;
      if (done !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0)
        begin bad++; $display("FAIL done_hold_%0d: done %b busy %b ready %b want 1 1 0", h, done, busy, in_ready); end
    end
    @(posedge clk); #1; start = 1'b1; done_ack = 1'b1;
    @(posedge clk); #1; start = 1'b0; done_ack = 1'b0;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0)
      begin bad++; $display("FAIL ack_start_ignored: done %b busy %b ready %b want 0 0 0", done, busy, in_ready); end
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL restart: ready %b busy %b want 1 1", in_ready, busy); end
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int j = 0; j < 16; j++) words[j] = $urandom;
    set_pattern(0);
    run_frame(9);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, rf_write, rf_small_or_big, round_en, busy, done} !== 6'b0 || round_idx !== 4'd0 || frame_flat !== '0)
      begin bad++; $display("FAIL mid_reset: ctrl %b frame %h want all 0", {in_ready, rf_write, rf_small_or_big, round_en, busy, done}, frame_flat); end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (rf_write !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL post_reset_idle: rf_write %b busy %b want 0 0", rf_write, busy); end
    end
    for (int j = 0; j < 16; j++) words[j] = $urandom;
    run_frame(99);
    total++;
    if (frame_flat !== model_frame()) begin bad++; $display("FAIL reload_frame: got %h want %h", frame_flat, model_frame()); end
    total++;
    if (done_cyc != 19 + RND) begin bad++; $display("FAIL reload_done: got %0d want %0d", done_cyc, 19 + RND); end
    @(posedge clk); #1 done_ack = 1'b1;
    @(posedge clk); #1 done_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stalls(input int mode);
    for (int j = 0; j < 16; j++) words[j] = $urandom;
    set_pattern(mode);
    spurious = (mode == 2);
    model_timing();
    run_frame(99);
    spurious = 1'b0;
    total++;
    if (hs_cyc.size() != 16) begin bad++; $display("FAIL stall%0d_hs_count: got %0d want 16", mode, hs_cyc.size()); end
    else for (int i = 0; i < 16; i++) begin
      total++;
      if (hs_cyc[i] != e_hs[i]) begin bad++; $display("FAIL stall%0d_hs_%0d: cycle %0d want %0d", mode, i, hs_cyc[i], e_hs[i]); end
    end
    total++;
    if (rf_cyc.size() != 2 || rf_cyc[0] != e_ws || rf_cyc[1] != e_wb || rf_sobv[0] !== 1'b0 || rf_sobv[1] !== 1'b1)
      begin bad++; $display("FAIL stall%0d_rf: count %0d want writes at %0d and %0d", mode, rf_cyc.size(), e_ws, e_wb); end
    total++;
    if (ren_cyc.size() != RND || ren_cyc[0] != e_wb + 1 || ren_idx[RND-1] != RND - 1)
      begin bad++; $display("FAIL stall%0d_rounds: count %0d want %0d from cycle %0d", mode, ren_cyc.size(), RND, e_wb + 1); end
    total++;
    if (done_cyc != e_done) begin bad++; $display("FAIL stall%0d_done: got %0d want %0d", mode, done_cyc, e_done); end
    total++;
    if (frame_flat !== model_frame()) begin bad++; $display("FAIL stall%0d_frame: got %h want %h", mode, frame_flat, model_frame()); end
    @(posedge clk); #1 done_ack = 1'b1;
    @(posedge clk); #1 done_ack = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL stall%0d_ack: busy %b done %b want 0 0", mode, busy, done); end
  endtask

`ifdef FRAME_SEQ_ABORT_EN
  task automatic test_abort();
    int hit = -1;
    int n = 0;
    for (int j = 0; j < 16; j++) words[j] = $urandom;
    for (int c = 0; c < 60 && hit < 0; c++) begin
      @(posedge clk); #1;
      start = (c == 0);
      in_valid = (c != 0);
      in_word = (n < 16) ? words[n] : 32'h0;
      @(negedge clk);
      if (in_valid && in_ready) n++;
      if (round_en && round_idx == 4'd3) begin hit = c; abort = 1'b1; end
    end
    start = 1'b0; in_valid = 1'b0;
    total++;
    if (hit != 22) begin bad++; $display("FAIL abort_round3_cycle: got %0d want 22", hit); end
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || round_en !== 1'b0 || rf_write !== 1'b0)
      begin bad++; $display("FAIL abort_idle: busy %b round_en %b rf_write %b want 0 0 0", busy, round_en, rf_write); end
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || round_en !== 1'b0) begin bad++; $display("FAIL abort_quiet: done %b round_en %b want 0 0", done, round_en); end
    end
    total++;
    if (frame_flat !== model_frame()) begin bad++; $display("FAIL abort_frame_kept: got %h want %h", frame_flat, model_frame()); end
  endtask
`endif

  initial begin
    spurious = 1'b0;
    test_reset();
    test_back_to_back();
    test_reset_mid_load();
    test_stalls(1);
    for (int r = 0; r < 3; r++) test_stalls(2);
`ifdef FRAME_SEQ_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
